uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver. Successor to the fixed 8N1 receiver: configurable data width, parity and stop bits, with 3-sample majority voting and a valid/ready output handshake. Reports overrun and break conditions. Sits between the pad-side rx line and the byte consumer (command decoder or FIFO).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_os.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver and its matching transmitter.
package uart_pkg;

    localparam int unsigned PARITY_NONE   = 0;
    localparam int unsigned PARITY_ODD    = 1;
    localparam int unsigned PARITY_EVEN   = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit a correct transmitter sends for the given (zero-extended) data word.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick every CLK_FREQ/(BAUD*OVERSAMPLE) clks.
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ   = 30_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_baud_tick: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable framing, 3-sample majority vote,
// valid/ready holding register with parity, framing, overrun and break reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 30_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = 4;
    localparam bit PAR_EN      = (PARITY != PARITY_NONE);

    generate
        if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_rx_os: parameter out of legal range");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop_err_q, stop_err_d;
    logic                   first_stop_q, first_stop_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   break_q, break_d;

    logic tick, rxs;
    logic bit_end_c, vote_pt_c, vote_c, last_data_c, last_stop_c, frame_done_c;
    logic first_stop_c, pe_c, fe_c, bd_c;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign rxs          = sync_q[1];
    assign bit_end_c    = tick && (scnt_q == SW'(OVERSAMPLE - 1));
    assign vote_pt_c    = tick && (scnt_q == SW'(M + 1));
    assign vote_c       = maj3(samp_q[1], samp_q[0], rxs);
    assign last_data_c  = (bcnt_q == BW'(DATA_BITS - 1));
    assign last_stop_c  = (bcnt_q == BW'(STOP_BITS - 1));
    assign frame_done_c = (state_q == ST_STOP) && vote_pt_c && last_stop_c;

    // Frame status as it stands at the final stop-bit vote.
    assign first_stop_c = (bcnt_q == BW'(0)) ? vote_c : first_stop_q;
    assign pe_c = PAR_EN && (par_bit_q != calc_parity(MAX_DATA_BITS'(shift_q), PARITY));
    assign fe_c = stop_err_q || !vote_c;
    assign bd_c = (shift_q == '0) && (!PAR_EN || !par_bit_q) && !first_stop_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (tick && !rxs) state_d = ST_START;
            ST_START: begin
                if (vote_pt_c && vote_c) state_d = ST_IDLE;
                else if (bit_end_c)      state_d = ST_DATA;
            end
            ST_DATA:      if (bit_end_c && last_data_c) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (bit_end_c) state_d = ST_STOP;
            ST_STOP:      if (frame_done_c) state_d = fe_c ? ST_WAIT_IDLE : ST_IDLE;
            ST_WAIT_IDLE: if (tick && rxs) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sync_d       = {sync_q[0], rx};
        scnt_d       = scnt_q;
        bcnt_d       = bcnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_err_d   = stop_err_q;
        first_stop_d = first_stop_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        break_d      = break_q;

        if (state_q == ST_IDLE || state_q == ST_WAIT_IDLE) begin
            scnt_d     = '0;
            bcnt_d     = '0;
            stop_err_d = 1'b0;
        end else if (tick) begin
            scnt_d = bit_end_c ? '0 : scnt_q + SW'(1);
        end

        if (tick && (scnt_q == SW'(M - 1) || scnt_q == SW'(M))) samp_d = {samp_q[0], rxs};

        if ((state_q == ST_DATA || state_q == ST_STOP) && bit_end_c)
            bcnt_d = (state_q == ST_DATA && last_data_c) ? '0 : bcnt_q + BW'(1);

        if (vote_pt_c) begin
            case (state_q)
                ST_DATA:   shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
                ST_PARITY: par_bit_d = vote_c;
                ST_STOP: begin
                    stop_err_d   = stop_err_q | ~vote_c;
                    first_stop_d = first_stop_c;
                end
                default: ;
            endcase
        end

        // A completing frame wins over a plain transfer; a busy register drops it.
        if (frame_done_c) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = pe_c;
                frame_err_d  = fe_c;
                break_d      = bd_c;
                rx_valid_d   = 1'b1;
                overrun_d    = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            scnt_q       <= '0;
            bcnt_q       <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            first_stop_q <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            scnt_q       <= scnt_d;
            bcnt_q       <= bcnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_err_q   <= stop_err_d;
            first_stop_q <= first_stop_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 7E1, 8N2) at 16 clks per bit.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       val_a, pe_a, fe_a, ov_a, bd_a;
    logic       val_b, pe_b, fe_b, ov_b, bd_b;
    logic       val_c, pe_c, fe_c, ov_c, bd_c;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a),
        .break_det(bd_a));

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                 .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b),
        .break_det(bd_b));

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_data(data_c), .rx_valid(val_c),
        .rx_ready(rdy_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c),
        .break_det(bd_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drive n line bits (LSB first), 16 clks each; clk index 'glitch' is inverted.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int glitch);
        logic v;
        for (int i = 0; i < n * 16; i++) begin
            v = bits[i / 16] ^ (i == glitch);
            set_rx(sel, v);
            wait_clks(1);
        end
        set_rx(sel, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        wait_clks(3);
        chk("reset_data",  32'(data_a), 32'h0);
        chk("reset_valid", 32'(val_a),  32'h0);
        chk("reset_pe",    32'(pe_a),   32'h0);
        chk("reset_fe",    32'(fe_a),   32'h0);
        chk("reset_ov",    32'(ov_a),   32'h0);
        chk("reset_bd",    32'(bd_a),   32'h0);
        rst_n = 1'b1;
        wait_clks(5);

        // False start: 4 low clks then idle
        set_rx(0, 1'b0);
        wait_clks(4);
        set_rx(0, 1'b1);
        wait_clks(40);
        chk("false_start_valid", 32'(val_a), 32'h0);
        chk("false_start_fe",    32'(fe_a),  32'h0);
        chk("false_start_bd",    32'(bd_a),  32'h0);

        // 8N1 0xA5 with a one-clk glitch at the first vote sample of data bit 2
        send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 56);
        chk("a5_data",  32'(data_a), 32'hA5);
        chk("a5_valid", 32'(val_a),  32'h1);
        chk("a5_pe",    32'(pe_a),   32'h0);
        chk("a5_fe",    32'(fe_a),   32'h0);
        chk("a5_bd",    32'(bd_a),   32'h0);
        chk("a5_ov",    32'(ov_a),   32'h0);
        wait_clks(20);
        chk("a5_valid_held", 32'(val_a), 32'h1);
        rdy_a = 1'b1;
        wait_clks(1);
        rdy_a = 1'b0;
        chk("a5_consumed", 32'(val_a), 32'h0);

        // Overrun: two frames without consuming
        send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, -1);
        send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10, -1);
        chk("ovr_data",  32'(data_a), 32'h11);
        chk("ovr_valid", 32'(val_a),  32'h1);
        chk("ovr_flag",  32'(ov_a),   32'h1);
        rdy_a = 1'b1;
        wait_clks(1);
        rdy_a = 1'b0;
        chk("ovr_clr_valid", 32'(val_a), 32'h0);
        chk("ovr_clr_flag",  32'(ov_a),  32'h0);
        wait_clks(5);
        send_bits(0, 16'({1'b1, 8'h33, 1'b0}), 10, -1);
        chk("after_ovr_data",  32'(data_a), 32'h33);
        chk("after_ovr_valid", 32'(val_a),  32'h1);
        chk("after_ovr_ov",    32'(ov_a),   32'h0);
        chk("after_ovr_fe",    32'(fe_a),   32'h0);
        rdy_a = 1'b1;
        wait_clks(1);
        rdy_a = 1'b0;

        // 7E1: 0x41 has two ones, so the correct even parity bit is 0
        send_bits(1, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, -1);
        chk("par_bad_data",  32'(data_b), 32'h41);
        chk("par_bad_valid", 32'(val_b),  32'h1);
        chk("par_bad_pe",    32'(pe_b),   32'h1);
        chk("par_bad_fe",    32'(fe_b),   32'h0);
        rdy_b = 1'b1;
        wait_clks(1);
        rdy_b = 1'b0;
        chk("par_bad_consumed", 32'(val_b), 32'h0);
        send_bits(1, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, -1);
        chk("par_ok_data",  32'(data_b), 32'h41);
        chk("par_ok_valid", 32'(val_b),  32'h1);
        chk("par_ok_pe",    32'(pe_b),   32'h0);
        chk("par_ok_fe",    32'(fe_b),   32'h0);
        rdy_b = 1'b1;
        wait_clks(1);
        rdy_b = 1'b0;

        // Break on 8N2: line low for 14 bit times, then kept low after consuming
        set_rx(2, 1'b0);
        wait_clks(224);
        chk("brk_valid", 32'(val_c),  32'h1);
        chk("brk_data",  32'(data_c), 32'h0);
        chk("brk_fe",    32'(fe_c),   32'h1);
        chk("brk_bd",    32'(bd_c),   32'h1);
        chk("brk_ov",    32'(ov_c),   32'h0);
        rdy_c = 1'b1;
        wait_clks(1);
        rdy_c = 1'b0;
        wait_clks(192);
        chk("brk_no_retrigger", 32'(val_c), 32'h0);
        chk("brk_no_overrun",   32'(ov_c),  32'h0);
        set_rx(2, 1'b1);
        wait_clks(40);
        send_bits(2, 16'({2'b11, 8'h5A, 1'b0}), 11, -1);
        chk("post_brk_data",  32'(data_c), 32'h5A);
        chk("post_brk_valid", 32'(val_c),  32'h1);
        chk("post_brk_fe",    32'(fe_c),   32'h0);
        chk("post_brk_bd",    32'(bd_c),   32'h0);
        rdy_c = 1'b1;
        wait_clks(1);
        rdy_c = 1'b0;

        // Reset during data bit 3 of 0x3C, line left idle afterwards
        send_bits(0, 16'({8'h3C, 1'b0}), 4, -1);
        wait_clks(6);
        rst_n = 1'b0;
        wait_clks(2);
        chk("mid_rst_data",  32'(data_a), 32'h0);
        chk("mid_rst_valid", 32'(val_a),  32'h0);
        chk("mid_rst_pe",    32'(pe_a),   32'h0);
        chk("mid_rst_fe",    32'(fe_a),   32'h0);
        chk("mid_rst_ov",    32'(ov_a),   32'h0);
        chk("mid_rst_bd",    32'(bd_a),   32'h0);
        rst_n = 1'b1;
        wait_clks(200);
        chk("mid_rst_discarded", 32'(val_a), 32'h0);
        send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
        chk("post_rst_data",  32'(data_a), 32'h3C);
        chk("post_rst_valid", 32'(val_a),  32'h1);
        chk("post_rst_fe",    32'(fe_a),   32'h0);
        chk("post_rst_ov",    32'(ov_a),   32'h0);
        chk("post_rst_bd",    32'(bd_a),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
